seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed display scheduler that shares one hex-to-7-segment decode path across `DIGITS` common-select digits, showing the full counter value instead of only its lowest nibble. It sits beside the counter in the user project. It latches a value snapshot, then steps a digit-select through fixed-length slots with a blanking guard at the start of each slot. It also handles segment polarity, leading-zero suppression and tear-free updates at frame boundaries.

## Interface
- `DIGITS`, 4: number of multiplexed digits; the value width is 4*DIGITS.
- `PRESCALE`, 1000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, 16: guard cycles at the start of each slot with all digits deselected; legal range 1 ≤ BLANK < PRESCALE.
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  synchronous reset, active-high.
- `value_in`  in  4*DIGITS  hex value to display; nibble i drives digit i.
- `load`  in  1  captures `value_in` into the shadow register on a clock edge where it is high.
- `enable`  in  1  1 = scanning, 0 = idle/blanked.
- `lz_suppress`  in  1  1 = blank leading zero digits.
- `seg_pol`  in  1  segment polarity: 1 = active-high, 0 = active-low.
- `seg_out`  out  7  segments {g,f,e,d,c,b,a} = bits [6:0].
- `seg_oeb`  out  7  segment output enables, active low.
- `digit_sel`  out  DIGITS  one-hot digit select, active-high.
- `frame_done`  out  1  one-cycle pulse at the end of each full frame.

## Operation
- **Registers:**
  - `shadow` (4*DIGITS) is written by `load`.
  - `active` (4*DIGITS) is the value currently scanned.
  - `idx` is the digit index, width $clog2(DIGITS), minimum 1.
  - `pcnt` is the slot counter, width $clog2(PRESCALE).
  - The FSM has three states: IDLE, BLANK, SHOW.
- **IDLE:**
  - `digit_sel` = 0.
  - `seg_out` = {7{~seg_pol}}.
  - `seg_oeb` = 7'h7F.
  - When `enable` = 1: go to BLANK with `idx` = 0, `pcnt` = 0, and copy `shadow` into `active`.
- **BLANK:**
  - `digit_sel` = 0, `seg_out` = {7{~seg_pol}}, `seg_oeb` = 0.
  - `pcnt` increments each cycle.
  - On the cycle `pcnt` = BLANK-1, go to SHOW.
- **SHOW:**
  - `digit_sel` = 1<<`idx`; `seg_oeb` = 0.
  - `seg_out` is the decoded `active` nibble at `idx`, XOR-inverted when `seg_pol` = 0.
  - On the cycle `pcnt` = PRESCALE-1: set `pcnt` to 0, increment `idx`, go to BLANK.
  - If `idx` was DIGITS-1: wrap `idx` to 0, pulse `frame_done`, and copy `shadow` into `active` (frame boundary).
- **Decode, active-high, segments 6..0:**
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- **Leading-zero suppression:** when `lz_suppress` = 1, digit i > 0 is blank if `active` nibbles DIGITS-1 down to i are all zero. A blank digit keeps its `digit_sel` asserted in SHOW, with `seg_out` = {7{~seg_pol}}. Digit 0 is never suppressed.
- **Input sampling:** `seg_pol` and `lz_suppress` are sampled every cycle and are not snapshotted.
- **`enable` deassertion:** any state goes to IDLE on the next edge. `idx` and `pcnt` are cleared.
- **`load` coinciding with a frame boundary or the IDLE→BLANK copy:** `value_in` is written to both `shadow` and `active` on that edge.
- **`load` mid-frame:** only `shadow` changes. The current frame finishes with the old `active`.

## Timing
- All outputs are registered. They reflect the state entered on the same edge.
- **Reset values:**
  - `digit_sel` = 0, `seg_out` = 7'h00, `seg_oeb` = 7'h7F, `frame_done` = 0.
  - `shadow` = `active` = 0, `idx` = `pcnt` = 0, state = IDLE.
- **Reset priority:** reset overrides everything, including mid-slot operation. No partial slot resumes after reset; scanning restarts from digit 0 only when `enable` is seen high after reset is released.
- **Start-up:** `enable` sampled high at edge t gives BLANK for digit 0 in cycles t+1…t+BLANK, then SHOW in cycles t+BLANK+1…t+PRESCALE.
- **Slot and frame period:** slot = PRESCALE cycles; frame = DIGITS×PRESCALE cycles.
- **`frame_done`:** high only during the first BLANK cycle of digit 0 of the next frame. It is never asserted in IDLE.
- **Select timing:** `digit_sel` never has more than one bit set. It is always 0 for at least BLANK cycles between any two different selects.

## Test plan
- **Reset values:** DIGITS=4, PRESCALE=8, BLANK=2. Assert reset for 3 cycles with `enable`=1 → `seg_oeb`=7F, `digit_sel`=0, `seg_out`=00, `frame_done`=0 during reset. Cycle 1 after release enters BLANK.
- **Scan sequence:** `load` 16'h12A5, `seg_pol`=1, then enable → `digit_sel` sequence 0,0,1(×6),0,0,2(×6),0,0,4(×6),0,0,8(×6). `seg_out` during each select is 1101101, 1110111, 1011011, 0000110. `frame_done` pulses every 32 cycles.
- **Leading-zero suppression:** `value_in`=16'h0007, `lz_suppress`=1, `seg_pol`=0 → digit 0 `seg_out`=1111000; digits 1–3 `seg_out`=1111111 with `digit_sel` still rotating. With `lz_suppress`=0, digits 1–3 show 1000000.
- **Tear-free update:** `load` 16'hFFFF while digit 1 is shown → digits 2–3 of the current frame still show 2 and 1. All digits show 1110001 starting with the first SHOW cycle of the next frame.
- **Load on boundary:** `load` of 16'h3333 on the same edge as the frame boundary → the new frame displays 3 on every digit with no old value.
- **Disable mid-operation:** drop `enable` during digit 2 SHOW → next cycle `digit_sel`=0 and `seg_oeb`=7F. Re-enable → restart at digit 0 BLANK.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed hex display scheduler.
// Shares one hex-to-7-segment decoder across DIGITS common-select digits.
// Each slot is PRESCALE cycles. The first BLANK cycles of a slot deselect every
// digit, so ghosting cannot occur while the select lines change.
// The displayed value is a snapshot ("active") that is refreshed from the
// shadow register only at frame boundaries, which keeps updates tear-free.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  lz_suppress,
    input  logic                  seg_pol,
    output logic [6:0]            seg_out,
    output logic [6:0]            seg_oeb,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int VW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [IW-1:0]     IDX_LAST     = IW'(DIGITS - 1);
    localparam logic [PW-1:0]     PC_BLANK_END = PW'(BLANK - 1);
    localparam logic [PW-1:0]     PC_SLOT_END  = PW'(PRESCALE - 1);
    localparam logic [DIGITS-1:0] SEL_ONE      = DIGITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t          state;
    logic [VW-1:0]   shadow;
    logic [VW-1:0]   active;
    logic [IW-1:0]   idx;
    logic [PW-1:0]   pcnt;

    logic            slot_end;
    logic            frame_end;
    logic            take_snapshot;
    logic [VW-1:0]   active_nxt;
    logic [IW-1:0]   idx_nxt;
    logic [DIGITS-1:0] lead_zero;
    logic            zero_above;
    logic [3:0]      show_nib;
    logic            show_blank;
    logic [6:0]      show_seg;
    logic [6:0]      seg_show_pol;
    logic [6:0]      seg_blank_pol;
    logic [DIGITS-1:0] sel_show;

    // Active-high hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Next snapshot/index and the segment pattern for the slot being entered.
    // Outputs are registered from these, so they describe the post-edge state.
    always_comb begin
        slot_end      = (state == ST_SHOW) && (pcnt == PC_SLOT_END);
        frame_end     = slot_end && (idx == IDX_LAST);
        take_snapshot = enable && ((state == ST_IDLE) || frame_end);

        active_nxt = active;
        if (take_snapshot) begin
            active_nxt = load ? value_in : shadow;
        end

        idx_nxt = idx;
        if (!enable || (state == ST_IDLE)) begin
            idx_nxt = '0;
        end else if (slot_end) begin
            idx_nxt = frame_end ? '0 : idx + IW'(1);
        end

        zero_above = 1'b1;
        lead_zero  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (active_nxt[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_above;
        end
        lead_zero[0] = 1'b0;

        show_nib   = 4'h0;
        show_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                show_nib   = active_nxt[4*i +: 4];
                show_blank = lz_suppress & lead_zero[i];
            end
        end

        show_seg      = show_blank ? 7'h00 : hex_to_seg(show_nib);
        seg_show_pol  = seg_pol ? show_seg : ~show_seg;
        seg_blank_pol = {7{~seg_pol}};
        sel_show      = SEL_ONE << idx_nxt;
    end

    // Scan FSM with registered outputs; enable low returns to IDLE from any state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            active     <= '0;
            idx        <= '0;
            pcnt       <= '0;
            digit_sel  <= '0;
            seg_out    <= 7'h00;
            seg_oeb    <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow <= value_in;
            end
            active     <= active_nxt;
            idx        <= idx_nxt;
            frame_done <= 1'b0;

            if (!enable) begin
                state     <= ST_IDLE;
                pcnt      <= '0;
                digit_sel <= '0;
                seg_out   <= seg_blank_pol;
                seg_oeb   <= 7'h7F;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_BLANK;
                        pcnt      <= '0;
                        digit_sel <= '0;
                        seg_out   <= seg_blank_pol;
                        seg_oeb   <= 7'h00;
                    end
                    ST_BLANK: begin
                        pcnt    <= pcnt + PW'(1);
                        seg_oeb <= 7'h00;
                        if (pcnt == PC_BLANK_END) begin
                            state     <= ST_SHOW;
                            digit_sel <= sel_show;
                            seg_out   <= seg_show_pol;
                        end else begin
                            digit_sel <= '0;
                            seg_out   <= seg_blank_pol;
                        end
                    end
                    ST_SHOW: begin
                        seg_oeb <= 7'h00;
                        if (slot_end) begin
                            state      <= ST_BLANK;
                            pcnt       <= '0;
                            digit_sel  <= '0;
                            seg_out    <= seg_blank_pol;
                            frame_done <= frame_end;
                        end else begin
                            pcnt      <= pcnt + PW'(1);
                            digit_sel <= sel_show;
                            seg_out   <= seg_show_pol;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        pcnt      <= '0;
                        digit_sel <= '0;
                        seg_out   <= seg_blank_pol;
                        seg_oeb   <= 7'h7F;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic, checked
// against a time-based model (slot position from elapsed scan cycles).
module tb_seg7_scan_ctrl;

    localparam int D  = 4;
    localparam int P  = 8;
    localparam int B  = 2;
    localparam int FR = D * P;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic        lz;
    logic        pol;
    logic [6:0]  seg_out;
    logic [6:0]  seg_oeb;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic        m_run    = 1'b0;
    int          m_t      = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [15:0] m_active = 16'h0;
    logic [3:0]  e_sel    = 4'h0;
    logic [6:0]  e_seg    = 7'h00;
    logic [6:0]  e_oeb    = 7'h7F;
    logic        e_fd     = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    logic [6:0] scan_seg [4] = '{7'b1101101, 7'b1110111, 7'b1011011, 7'b0000110};

    seg7_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .value_in    (value),
        .load        (load),
        .enable      (enable),
        .lz_suppress (lz),
        .seg_pol     (pol),
        .seg_out     (seg_out),
        .seg_oeb     (seg_oeb),
        .digit_sel   (digit_sel),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and update the model from the inputs seen at it.
    task automatic tick();
        logic       snap;
        logic       blank_d;
        logic [6:0] s;
        int         pos;
        int         dig;
        @(posedge clk);
        snap = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_t = 0; m_shadow = 16'h0; m_active = 16'h0;
            e_sel = 4'h0; e_seg = 7'h00; e_oeb = 7'h7F; e_fd = 1'b0;
        end else begin
            if (!enable) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1; m_t = 0; snap = 1'b1;
            end else begin
                m_t++;
                snap = (m_t % FR == 0);
            end
            if (snap) m_active = load ? value : m_shadow;
            if (load) m_shadow = value;
            if (!m_run) begin
                e_sel = 4'h0; e_seg = {7{~pol}}; e_oeb = 7'h7F; e_fd = 1'b0;
            end else begin
                pos   = m_t % P;
                dig   = (m_t / P) % D;
                e_fd  = (m_t > 0) && (m_t % FR == 0);
                e_oeb = 7'h00;
                if (pos < B) begin
                    e_sel = 4'h0;
                    e_seg = {7{~pol}};
                end else begin
                    e_sel   = 4'(1 << dig);
                    blank_d = lz && (dig > 0) && ((m_active >> (4 * dig)) == 16'h0);
                    s       = blank_d ? 7'h00 : seg_tab[m_active[4*dig +: 4]];
                    e_seg   = pol ? s : ~s;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; load = 1'b0; value = 16'hBEEF; lz = 1'b0; pol = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {4'h0, 7'h00, 7'h7F, 1'b0}) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=0 seg=0 oeb=7f fd=0",
                         k, digit_sel, seg_out, seg_oeb, frame_done);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({digit_sel, seg_out, seg_oeb, frame_done} !== {4'h0, 7'h00, 7'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got sel=%b seg=%b oeb=%h fd=%b, want BLANK sel=0 seg=0 oeb=0 fd=0",
                     digit_sel, seg_out, seg_oeb, frame_done);
        end
    endtask

    task automatic test_scan();
        int       dig;
        int       n_fd;
        logic [3:0] xs;
        do_reset();
        value = 16'h12A5; load = 1'b1; pol = 1'b1; lz = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
        n_fd = 0;
        for (int k = 0; k < 2 * FR + 1; k++) begin
            tick();
            if (frame_done === 1'b1) n_fd++;
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {e_sel, e_seg, e_oeb, e_fd}) begin
                n_fail++;
                $display("FAIL scan_model t=%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=%b seg=%b oeb=%h fd=%b",
                         m_t, digit_sel, seg_out, seg_oeb, frame_done, e_sel, e_seg, e_oeb, e_fd);
            end
            if (m_t % P >= B) begin
                dig = (m_t / P) % D;
                xs  = 4'b0001 << dig;
                n_cmp++;
                if (digit_sel !== xs || seg_out !== scan_seg[dig]) begin
                    n_fail++;
                    $display("FAIL scan_digit t=%0d: got sel=%b seg=%b, want sel=%b seg=%b",
                             m_t, digit_sel, seg_out, xs, scan_seg[dig]);
                end
            end
        end
        n_cmp++;
        if (n_fd != 2) begin
            n_fail++;
            $display("FAIL scan_frame_count: got %0d pulses, want 2", n_fd);
        end
    endtask

    task automatic test_lz();
        int       dig;
        logic [6:0] xseg;
        do_reset();
        value = 16'h0007; load = 1'b1; pol = 1'b0; lz = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k < 2 * FR; k++) begin
            if (k == FR) lz = 1'b0;
            tick();
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {e_sel, e_seg, e_oeb, e_fd}) begin
                n_fail++;
                $display("FAIL lz_model t=%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=%b seg=%b oeb=%h fd=%b",
                         m_t, digit_sel, seg_out, seg_oeb, frame_done, e_sel, e_seg, e_oeb, e_fd);
            end
            if (m_t % P >= B) begin
                dig  = (m_t / P) % D;
                xseg = (dig == 0) ? 7'b1111000 : (lz ? 7'b1111111 : 7'b1000000);
                n_cmp++;
                if (seg_out !== xseg || digit_sel !== 4'(1 << dig)) begin
                    n_fail++;
                    $display("FAIL lz_digit t=%0d lz=%b: got sel=%b seg=%b, want seg=%b",
                             m_t, lz, digit_sel, seg_out, xseg);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        int       dig;
        logic [6:0] xseg;
        do_reset();
        value = 16'h12A5; load = 1'b1; pol = 1'b1; lz = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k < 2 * FR; k++) begin
            if (k == P + B + 1) begin load = 1'b1; value = 16'hFFFF; end
            else load = 1'b0;
            tick();
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {e_sel, e_seg, e_oeb, e_fd}) begin
                n_fail++;
                $display("FAIL tear_model t=%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=%b seg=%b oeb=%h fd=%b",
                         m_t, digit_sel, seg_out, seg_oeb, frame_done, e_sel, e_seg, e_oeb, e_fd);
            end
            if (m_t % P >= B) begin
                dig  = (m_t / P) % D;
                xseg = (m_t < FR) ? scan_seg[dig] : 7'b1110001;
                n_cmp++;
                if (seg_out !== xseg) begin
                    n_fail++;
                    $display("FAIL tear_digit t=%0d: got seg=%b, want seg=%b", m_t, seg_out, xseg);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        int       dig;
        logic [6:0] xseg;
        do_reset();
        value = 16'h12A5; load = 1'b1; pol = 1'b1; lz = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k < 2 * FR; k++) begin
            if (k == FR) begin load = 1'b1; value = 16'h3333; end
            else load = 1'b0;
            tick();
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {e_sel, e_seg, e_oeb, e_fd}) begin
                n_fail++;
                $display("FAIL boundary_model t=%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=%b seg=%b oeb=%h fd=%b",
                         m_t, digit_sel, seg_out, seg_oeb, frame_done, e_sel, e_seg, e_oeb, e_fd);
            end
            if (m_t % P >= B) begin
                dig  = (m_t / P) % D;
                xseg = (m_t < FR) ? scan_seg[dig] : 7'b1001111;
                n_cmp++;
                if (seg_out !== xseg) begin
                    n_fail++;
                    $display("FAIL boundary_digit t=%0d: got seg=%b, want seg=%b", m_t, seg_out, xseg);
                end
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        value = 16'h12A5; load = 1'b1; pol = 1'b1; lz = 1'b0;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int k = 0; k <= 2 * P + B + 1; k++) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if ({digit_sel, seg_out, seg_oeb, frame_done} !== {4'h0, 7'h00, 7'h7F, 1'b0}) begin
            n_fail++;
            $display("FAIL disable: got sel=%b seg=%b oeb=%h fd=%b, want sel=0 seg=0 oeb=7f fd=0",
                     digit_sel, seg_out, seg_oeb, frame_done);
        end
        for (int k = 0; k < 3; k++) tick();
        enable = 1'b1;
        tick();
        n_cmp++;
        if ({digit_sel, seg_out, seg_oeb, frame_done} !== {4'h0, 7'h00, 7'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reenable: got sel=%b seg=%b oeb=%h fd=%b, want sel=0 seg=0 oeb=0 fd=0",
                     digit_sel, seg_out, seg_oeb, frame_done);
        end
        for (int k = 0; k < P; k++) begin
            tick();
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {e_sel, e_seg, e_oeb, e_fd}) begin
                n_fail++;
                $display("FAIL reenable_model t=%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=%b seg=%b oeb=%h fd=%b",
                         m_t, digit_sel, seg_out, seg_oeb, frame_done, e_sel, e_seg, e_oeb, e_fd);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            rst    = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 59) != 0);
            load   = ($urandom_range(0, 9) == 0);
            value  = 16'($urandom);
            if ($urandom_range(0, 99) == 0) pol = ~pol;
            if ($urandom_range(0, 49) == 0) lz = ~lz;
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            tick();
            n_cmp++;
            if ({digit_sel, seg_out, seg_oeb, frame_done} !== {e_sel, e_seg, e_oeb, e_fd}) begin
                n_fail++;
                $display("FAIL random k=%0d t=%0d: got sel=%b seg=%b oeb=%h fd=%b, want sel=%b seg=%b oeb=%h fd=%b",
                         k, m_t, digit_sel, seg_out, seg_oeb, frame_done, e_sel, e_seg, e_oeb, e_fd);
            end
            n_cmp++;
            if (!$onehot0(digit_sel)) begin
                n_fail++;
                $display("FAIL random_onehot k=%0d: got sel=%b, want at most one bit set", k, digit_sel);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; value = 16'h0; load = 1'b0; enable = 1'b0; lz = 1'b0; pol = 1'b1;
        test_reset();
        test_scan();
        test_lz();
        test_tear_free();
        test_boundary_load();
        test_disable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
